// File: rtl/alu_instr_sequencer.sv
// Microsequencer that steps the bus-based datapath through fetch, decode and
// execute of one register-register ALU instruction, including MUL/DIV HI/LO writeback.
module alu_instr_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 16,
    parameter int OP_W         = 5,
    parameter int OP_RTYPE_MAX = 12,
    parameter int OP_MUL       = 15,
    parameter int OP_DIV       = 16
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] IR,
    input  logic                  mem_ready,
    input  logic                  alu_done,
    output logic                  PCout,
    output logic                  Zlowout,
    output logic                  Zhighout,
    output logic                  MDRout,
    output logic                  MARin,
    output logic                  Zin,
    output logic                  PCin,
    output logic                  MDRin,
    output logic                  IRin,
    output logic                  Yin,
    output logic                  HIin,
    output logic                  LOin,
    output logic                  IncPC,
    output logic                  Read,
    output logic [NUM_REGS-1:0]   Rin,
    output logic [NUM_REGS-1:0]   Rout,
    output logic [OP_W-1:0]       alu_op,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal
);

    localparam int RF_W = 4;
    localparam logic [OP_W-1:0] RTYPE_MAX_C = OP_W'(OP_RTYPE_MAX);
    localparam logic [OP_W-1:0] MUL_C       = OP_W'(OP_MUL);
    localparam logic [OP_W-1:0] DIV_C       = OP_W'(OP_DIV);
    localparam logic [RF_W:0]   NREGS_C     = 5'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    state_t            state_r, state_next_s;
    logic [OP_W-1:0]   op_s, op_r;
    logic [RF_W-1:0]   ra_s, rb_s, rc_s, ra_r, rb_r, rc_r;
    logic              is_rtype_s, is_mul_s, is_div_s, illegal_s;
    logic              rtype_r, div_r;
    logic              unused_ir_s;

    function automatic logic reg_bad(input logic [RF_W-1:0] idx);
        return {1'b0, idx} >= NREGS_C;
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot(input logic [RF_W-1:0] idx);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign op_s = IR[DATA_WIDTH-1 -: OP_W];
    assign ra_s = IR[DATA_WIDTH-OP_W-1 -: RF_W];
    assign rb_s = IR[DATA_WIDTH-OP_W-RF_W-1 -: RF_W];
    assign rc_s = IR[DATA_WIDTH-OP_W-2*RF_W-1 -: RF_W];
    assign unused_ir_s = ^IR[DATA_WIDTH-OP_W-3*RF_W-1:0];

    assign is_rtype_s = (op_s <= RTYPE_MAX_C);
    assign is_mul_s   = (op_s == MUL_C);
    assign is_div_s   = (op_s == DIV_C);
    // Rc only matters for three-register ops; MUL/DIV ignore it
    assign illegal_s  = !(is_rtype_s || is_mul_s || is_div_s) || reg_bad(ra_s) ||
                        reg_bad(rb_s) || (is_rtype_s && reg_bad(rc_s));

    // State register
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Hold the decoded instruction so execute does not depend on IR staying stable
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            op_r    <= '0;
            ra_r    <= '0;
            rb_r    <= '0;
            rc_r    <= '0;
            rtype_r <= 1'b0;
            div_r   <= 1'b0;
        end else if (state_r == S_T3) begin
            op_r    <= op_s;
            ra_r    <= ra_s;
            rb_r    <= rb_s;
            rc_r    <= rc_s;
            rtype_r <= is_rtype_s;
            div_r   <= is_div_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE:  if (start) state_next_s = S_T0; else state_next_s = S_IDLE;
            S_T0:    state_next_s = S_T1;
            S_T1:    if (mem_ready) state_next_s = S_T2; else state_next_s = S_T1;
            S_T2:    state_next_s = S_T3;
            S_T3:    if (illegal_s) state_next_s = S_IDLE; else state_next_s = S_T4;
            S_T4:    if (!div_r || alu_done) state_next_s = S_T5; else state_next_s = S_T4;
            S_T5:    if (rtype_r) state_next_s = S_IDLE; else state_next_s = S_T6;
            S_T6:    state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
        MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; IncPC = 1'b0; Read = 1'b0;
        Rin = '0; Rout = '0; alu_op = '0;
        busy = 1'b1; done = 1'b0; illegal = 1'b0;
        case (state_r)
            S_IDLE: busy = 1'b0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                Read = 1'b1; MDRin = 1'b1; Zlowout = 1'b1; PCin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                if (illegal_s) begin
                    illegal = 1'b1;
                end else begin
                    Rout = onehot(rb_s);
                    Yin  = 1'b1;
                end
            end
            S_T4: begin
                alu_op = op_r;
                if (div_r) begin
                    Rout = onehot(rb_r);
                    Zin  = alu_done;
                end else begin
                    Rout = onehot(rtype_r ? rc_r : rb_r);
                    Zin  = 1'b1;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (rtype_r) begin
                    Rin  = onehot(ra_r);
                    done = 1'b1;
                end else begin
                    LOin = 1'b1;
                end
            end
            S_T6: begin
                Zhighout = 1'b1; HIin = 1'b1; done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Randomised self-checking bench for alu_instr_sequencer: expected per-cycle strobes
// come from a cycle-list model built from the instruction's fetch/decode/execute rules.
module tb_alu_instr_sequencer;

    typedef struct packed {
        logic PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin;
        logic Yin, HIin, LOin, IncPC, Read, busy, done, illegal;
        logic [15:0] Rin;
        logic [15:0] Rout;
        logic [4:0]  alu_op;
    } out_t;

    logic Clock = 1'b0;
    logic clear, start, mem_ready, alu_done;
    logic [31:0] IR;

    logic a_PCout, a_Zlowout, a_Zhighout, a_MDRout, a_MARin, a_Zin, a_PCin, a_MDRin, a_IRin;
    logic a_Yin, a_HIin, a_LOin, a_IncPC, a_Read, a_busy, a_done, a_illegal;
    logic [15:0] a_Rin, a_Rout;
    logic [4:0]  a_alu_op;
    logic b_PCout, b_Zlowout, b_Zhighout, b_MDRout, b_MARin, b_Zin, b_PCin, b_MDRin, b_IRin;
    logic b_Yin, b_HIin, b_LOin, b_IncPC, b_Read, b_busy, b_done, b_illegal;
    logic [7:0]  b_Rin, b_Rout;
    logic [4:0]  b_alu_op;

    out_t obs16, obs8;
    assign obs16 = {a_PCout, a_Zlowout, a_Zhighout, a_MDRout, a_MARin, a_Zin, a_PCin, a_MDRin,
                    a_IRin, a_Yin, a_HIin, a_LOin, a_IncPC, a_Read, a_busy, a_done, a_illegal,
                    a_Rin, a_Rout, a_alu_op};
    assign obs8  = {b_PCout, b_Zlowout, b_Zhighout, b_MDRout, b_MARin, b_Zin, b_PCin, b_MDRin,
                    b_IRin, b_Yin, b_HIin, b_LOin, b_IncPC, b_Read, b_busy, b_done, b_illegal,
                    8'h00, b_Rin, 8'h00, b_Rout, b_alu_op};

    alu_instr_sequencer dut (
        .Clock(Clock), .clear(clear), .start(start), .IR(IR), .mem_ready(mem_ready),
        .alu_done(alu_done), .PCout(a_PCout), .Zlowout(a_Zlowout), .Zhighout(a_Zhighout),
        .MDRout(a_MDRout), .MARin(a_MARin), .Zin(a_Zin), .PCin(a_PCin), .MDRin(a_MDRin),
        .IRin(a_IRin), .Yin(a_Yin), .HIin(a_HIin), .LOin(a_LOin), .IncPC(a_IncPC),
        .Read(a_Read), .Rin(a_Rin), .Rout(a_Rout), .alu_op(a_alu_op), .busy(a_busy),
        .done(a_done), .illegal(a_illegal));

    alu_instr_sequencer #(.NUM_REGS(8)) dut8 (
        .Clock(Clock), .clear(clear), .start(start), .IR(IR), .mem_ready(mem_ready),
        .alu_done(alu_done), .PCout(b_PCout), .Zlowout(b_Zlowout), .Zhighout(b_Zhighout),
        .MDRout(b_MDRout), .MARin(b_MARin), .Zin(b_Zin), .PCin(b_PCin), .MDRin(b_MDRin),
        .IRin(b_IRin), .Yin(b_Yin), .HIin(b_HIin), .LOin(b_LOin), .IncPC(b_IncPC),
        .Read(b_Read), .Rin(b_Rin), .Rout(b_Rout), .alu_op(b_alu_op), .busy(b_busy),
        .done(b_done), .illegal(b_illegal));

    always #5 Clock = ~Clock;

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t exp_q[$];
    bit   exp_div;
    int   exp_done, exp_ill;
    int   busy_cnt, done_cnt, ill_cnt;

    function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
        return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'h0000};
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] i);
        logic [15:0] one;
        one = 16'h0001;
        return one << i;
    endfunction

    // Expected cycle list from T0 to the last busy cycle.
    task automatic model_build(input logic [31:0] ir, input int mw, input int dw, input int nregs);
        out_t c;
        int op, ra, rb, rc;
        bit rt, mu, dv, bad;
        op = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
        rt = (op <= 12); mu = (op == 15); dv = (op == 16);
        bad = !(rt || mu || dv) || ra >= nregs || rb >= nregs || (rt && rc >= nregs);
        exp_q.delete();
        c = '0; c.busy = 1; c.PCout = 1; c.MARin = 1; c.IncPC = 1; c.Zin = 1; exp_q.push_back(c);
        for (int i = 0; i <= mw; i++) begin
            c = '0; c.busy = 1; c.Read = 1; c.MDRin = 1; c.Zlowout = 1; c.PCin = 1;
            exp_q.push_back(c);
        end
        c = '0; c.busy = 1; c.MDRout = 1; c.IRin = 1; exp_q.push_back(c);
        exp_div = dv && !bad;
        exp_done = bad ? 0 : 1;
        exp_ill  = bad ? 1 : 0;
        if (bad) begin
            c = '0; c.busy = 1; c.illegal = 1; exp_q.push_back(c);
            return;
        end
        c = '0; c.busy = 1; c.Yin = 1; c.Rout = oh(4'(rb)); exp_q.push_back(c);
        for (int i = 0; i <= (dv ? dw : 0); i++) begin
            c = '0; c.busy = 1; c.alu_op = 5'(op); c.Rout = oh(4'(rt ? rc : rb));
            c.Zin = dv ? (i == dw) : 1'b1;
            exp_q.push_back(c);
        end
        if (rt) begin
            c = '0; c.busy = 1; c.Zlowout = 1; c.Rin = oh(4'(ra)); c.done = 1; exp_q.push_back(c);
        end else begin
            c = '0; c.busy = 1; c.Zlowout = 1; c.LOin = 1; exp_q.push_back(c);
            c = '0; c.busy = 1; c.Zhighout = 1; c.HIin = 1; c.done = 1; exp_q.push_back(c);
        end
    endtask

    // Entered #1 after a rising edge with the DUT idle; leaves #1 after the edge back into IDLE.
    // smode: 0 start low while busy, 1 random start while busy, k+2 start pulse on cycle k.
    task automatic run_instr(input logic [31:0] ir, input int mw, input int dw,
                             input int nregs, input int smode);
        out_t o;
        model_build(ir, mw, dw, nregs);
        IR = ir; start = 1'b1;
        mem_ready = 1'($urandom); alu_done = 1'($urandom);
        @(negedge Clock);
        o = (nregs == 8) ? obs8 : obs16;
        n_checks++;
        if (o !== out_t'('0)) begin
            n_fail++;
            $display("FAIL idle_before ir=%h: got %h expected 0", ir, o);
        end
        busy_cnt = 0; done_cnt = 0; ill_cnt = 0;
        @(posedge Clock); #1;
        for (int k = 0; k < exp_q.size(); k++) begin
            start     = (smode == 0) ? 1'b0 : (smode == 1) ? 1'($urandom) : (k == smode - 2);
            mem_ready = (k >= 1 && k <= mw) ? 1'b0 : (k == mw + 1) ? 1'b1 : 1'($urandom);
            alu_done  = (exp_div && k >= 4 + mw && k < 4 + mw + dw) ? 1'b0 :
                        (exp_div && k == 4 + mw + dw) ? 1'b1 : 1'($urandom);
            @(negedge Clock);
            o = (nregs == 8) ? obs8 : obs16;
            n_checks++;
            if (o !== exp_q[k]) begin
                n_fail++;
                $display("FAIL cycle%0d ir=%h nregs=%0d: got %h expected %h", k, ir, nregs, o, exp_q[k]);
            end
            busy_cnt += int'(o.busy); done_cnt += int'(o.done); ill_cnt += int'(o.illegal);
            @(posedge Clock); #1;
        end
        start = 1'b0;
        n_checks++;
        if (done_cnt != exp_done || ill_cnt != exp_ill) begin
            n_fail++;
            $display("FAIL pulses ir=%h: done=%0d illegal=%0d expected %0d/%0d",
                     ir, done_cnt, ill_cnt, exp_done, exp_ill);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge Clock); #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b0; mem_ready = 1'b0; alu_done = 1'b0; IR = '0;
        @(negedge Clock);
        n_checks++;
        if (obs16 !== out_t'('0) || obs8 !== out_t'('0)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h / %h expected 0", obs16, obs8);
        end
        @(posedge Clock); #1;
        clear = 1'b0;
        IR = mk_ir(5, 1, 2, 3); start = 1'b1; mem_ready = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        n_checks++;
        if (a_busy !== 1'b1 || a_alu_op !== 5'd5 || a_Rout !== 16'h0008) begin
            n_fail++;
            $display("FAIL reach_t4: busy=%b alu_op=%0d Rout=%h expected 1/5/0008", a_busy, a_alu_op, a_Rout);
        end
        #2 clear = 1'b1;
        #1;
        n_checks++;
        if (obs16 !== out_t'('0) || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear: got %h expected 0", obs16);
        end
        @(posedge Clock); #1;
        n_checks++;
        if (obs16 !== out_t'('0)) begin
            n_fail++;
            $display("FAIL clear_held: got %h expected 0", obs16);
        end
        clear = 1'b0;
        run_instr(mk_ir(5, 1, 2, 3), 0, 0, 16, 0);
    endtask

    task automatic test_rtype();
        run_instr(32'h2891_8000, 0, 0, 16, 0);
        n_checks++;
        if (busy_cnt != 6) begin
            n_fail++;
            $display("FAIL rtype_busy: got %0d cycles expected 6", busy_cnt);
        end
    endtask

    task automatic test_mul();
        run_instr(mk_ir(15, 4, 5, 6), 0, 0, 16, 0);
        n_checks++;
        if (busy_cnt != 7) begin
            n_fail++;
            $display("FAIL mul_busy: got %0d cycles expected 7", busy_cnt);
        end
    endtask

    task automatic test_div();
        run_instr(mk_ir(16, 3, 7, 2), 2, 3, 16, 0);
        n_checks++;
        if (busy_cnt != 12) begin
            n_fail++;
            $display("FAIL div_busy: got %0d cycles expected 12", busy_cnt);
        end
    endtask

    task automatic test_illegal();
        run_instr(mk_ir(20, 1, 2, 3), 0, 0, 16, 0);
        n_checks++;
        if (busy_cnt != 4) begin
            n_fail++;
            $display("FAIL illegal_busy: got %0d cycles expected 4", busy_cnt);
        end
        pulse_clear();
        run_instr(mk_ir(5, 1, 2, 9), 0, 0, 8, 0);
        n_checks++;
        if (busy_cnt != 4) begin
            n_fail++;
            $display("FAIL nregs8_busy: got %0d cycles expected 4", busy_cnt);
        end
        pulse_clear();
        run_instr(mk_ir(15, 1, 2, 9), 1, 0, 8, 0);
        n_checks++;
        if (busy_cnt != 8) begin
            n_fail++;
            $display("FAIL nregs8_mul_busy: got %0d cycles expected 8", busy_cnt);
        end
        pulse_clear();
    endtask

    task automatic test_start_ignored();
        run_instr(mk_ir(7, 9, 10, 11), 0, 0, 16, 4);
        run_instr(mk_ir(0, 15, 14, 13), 1, 0, 16, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            int op;
            op = (i % 4 == 0) ? 16 : (i % 4 == 1) ? 15 : int'($urandom_range(31, 0));
            run_instr(mk_ir(op, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                            int'($urandom_range(15, 0))),
                      int'($urandom_range(3, 0)), int'($urandom_range(4, 0)), 16, 1);
        end
        @(negedge Clock);
        n_checks++;
        if (obs16 !== out_t'('0)) begin
            n_fail++;
            $display("FAIL final_idle: got %h expected 0", obs16);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_mul();
        test_div();
        test_illegal();
        test_start_ignored();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
